// File: rtl/pdp8l_rk8je_pkg.sv
// Shared constants for the RK8JE-style disk IOT interface: status bit
// positions, command function codes, IOP function codes and the ARM ID word.
package pdp8l_rk8je_pkg;

  localparam logic [31:0] RK_ID_WORD  = 32'h524B3004;
  localparam logic [31:0] RK_BAD_ADDR = 32'hDEADBEEF;

  // Status register bit positions
  localparam int ST_DONE = 11;
  localparam int ST_HDIM = 10;
  localparam int ST_LATE = 9;
  localparam int ST_SERR = 8;
  localparam int ST_FLNR = 7;
  localparam int ST_CBSY = 6;
  localparam int ST_TIME = 5;
  localparam int ST_WLO  = 4;
  localparam int ST_DRVE = 3;
  localparam int ST_DATA = 2;
  localparam int ST_PAR  = 1;
  localparam int ST_CYLR = 0;

  // Command function field, command[11:9]
  localparam logic [2:0] FN_READ  = 3'd0;
  localparam logic [2:0] FN_RALL  = 3'd1;
  localparam logic [2:0] FN_WPRT  = 3'd2;
  localparam logic [2:0] FN_SEEK  = 3'd3;
  localparam logic [2:0] FN_WRITE = 3'd4;

  // IOP function codes, ioopcode[2:0]
  localparam logic [2:0] IOP_DSKP = 3'd1;
  localparam logic [2:0] IOP_DCLR = 3'd2;
  localparam logic [2:0] IOP_DLAG = 3'd3;
  localparam logic [2:0] IOP_DLCA = 3'd4;
  localparam logic [2:0] IOP_DRST = 3'd5;
  localparam logic [2:0] IOP_DLDC = 3'd6;

  // Status bits that make DSKP skip / raise the completion interrupt
  localparam logic [11:0] ST_SKIP_MASK = 12'hBBF;

  function automatic logic stskip_of(input logic [11:0] st);
    return |(st & ST_SKIP_MASK);
  endfunction

endpackage

// File: rtl/rk8je_seek_timer.sv
// One drive's seek timer: loads SEEKTICKS on a seek, counts down on each
// prescaler tick and pulses expire on the 1->0 transition.
module rk8je_seek_timer
  import pdp8l_rk8je_pkg::*;
#(
  parameter int SEEKTICKS = 10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       tick,
  input  logic       load,
  input  logic       clear,
  output logic       busy,
  output logic       expire,
  output logic [7:0] count
);

  localparam logic [7:0] SEEK_LOAD = 8'(SEEKTICKS);

  logic [7:0] count_q, count_d;

  // Next count: clear beats a restart, a restart beats a countdown
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    count_d = count_q;
    expire  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = SEEK_LOAD;
    end else if (tick && count_q != 8'd0) begin
      count_d = count_q - 8'd1;
      expire  = (count_q == 8'd1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge CLOCK) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

  assign busy  = (count_q != 8'd0);
  assign count = count_q;

endmodule

// File: rtl/pdp8l_rk8je_multi.sv
// RK8JE-style multi-drive disk IOT interface: decodes the 67xx IOPs, holds
// command/disk-address/memory-address/status, hands transfers to the ARM
// and tracks per-drive seeks with timers and seek-done interrupts.
module pdp8l_rk8je_multi
  import pdp8l_rk8je_pkg::*;
#(
  parameter logic [5:0] DEVCODE   = 6'o74,
  parameter int         NDRIVES   = 4,
  parameter int         TICKDIV   = 50000,
  parameter int         SEEKTICKS = 10
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        BINIT,
  input  logic        armwrite,
  input  logic [3:0]  armraddr,
  input  logic [3:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        iopstart,
  input  logic        iopstop,
  input  logic [11:0] ioopcode,
  input  logic [11:0] cputodev,
  output logic [11:0] devtocpu,
  output logic        AC_CLEAR,
  output logic        IO_SKIP,
  output logic        INT_RQST
);

  localparam int PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKDIV - 1);

  logic [11:0] command_q, command_d;
  logic [11:0] diskaddr_q, diskaddr_d;
  logic [11:0] memaddr_q, memaddr_d;
  logic [11:0] status_q, status_d;
  logic        startio_q, startio_d;
  logic        stbusy_q, stbusy_d;
  logic        enable_q, enable_d;
  logic [3:0]  seekdone_q, seekdone_d;
  logic [3:0][7:0] cyl_q, cyl_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [11:0] devtocpu_q, devtocpu_d;
  logic        ac_clear_q, ac_clear_d;
  logic        io_skip_q, io_skip_d;

  logic        rst_any, seek_tick, iop_hit, stskip, done_hit;
  logic [2:0]  iop_func;
  logic [1:0]  drv;
  logic [3:0]  timer_busy, timer_expire, timer_load;
  logic        timer_clear;
  logic [3:0][7:0] timer_count;
  logic        unused_bits;

  assign rst_any   = RESET | BINIT;
  assign seek_tick = (prescaler_q == PS_LAST);
  assign iop_func  = ioopcode[2:0];
  assign iop_hit   = iopstart & enable_q &
                     (ioopcode[11:9] == 3'o6) & (ioopcode[8:3] == DEVCODE);
  assign drv       = command_q[2:1];
  assign stskip    = stskip_of(status_q);
  assign done_hit  = timer_expire[drv] & command_q[7];
  assign unused_bits = ^armwdata[31:12];

  // One timer per present drive; absent drives never look busy
  for (genvar g = 0; g < 4; g++) begin : g_drive
    if (g < NDRIVES) begin : g_present
      rk8je_seek_timer #(.SEEKTICKS(SEEKTICKS)) u_timer (
        .CLOCK  (CLOCK),
        .RESET  (rst_any),
        .tick   (seek_tick),
        .load   (timer_load[g]),
        .clear  (timer_clear),
        .busy   (timer_busy[g]),
        .expire (timer_expire[g]),
        .count  (timer_count[g])
      );
    end else begin : g_absent
      assign timer_busy[g]   = 1'b0;
      assign timer_expire[g] = 1'b0;
      assign timer_count[g]  = '0;
    end
  end

  // Next-state: ARM write beats IOP beats iopstop; seek expiry merged last
  always_comb begin
    command_d   = command_q;
    diskaddr_d  = diskaddr_q;
    memaddr_d   = memaddr_q;
    status_d    = status_q;
    startio_d   = startio_q;
    stbusy_d    = stbusy_q;
    enable_d    = enable_q;
    seekdone_d  = seekdone_q;
    cyl_d       = cyl_q;
    devtocpu_d  = devtocpu_q;
    ac_clear_d  = ac_clear_q;
    io_skip_d   = io_skip_q;
    timer_load  = '0;
    timer_clear = 1'b0;
    prescaler_d = seek_tick ? '0 : prescaler_q + 1'b1;

    if (armwrite) begin
      case (armwaddr)
        4'd1: command_d  = armwdata[11:0];
        4'd2: diskaddr_d = armwdata[11:0];
        4'd3: memaddr_d  = armwdata[11:0];
        4'd4: status_d   = armwdata[11:0];
        4'd5: {stbusy_d, startio_d, enable_d} = armwdata[2:0];
        4'd7: seekdone_d = seekdone_q & ~armwdata[3:0];
        4'd8, 4'd9, 4'd10, 4'd11: cyl_d[armwaddr[1:0]] = armwdata[7:0];
        default: ;
      endcase
    end else if (iop_hit) begin
      case (iop_func)
        IOP_DSKP: io_skip_d = stskip;
        IOP_DCLR: begin
          case (cputodev[1:0])
            2'd0: begin
              if (stbusy_q) status_d[ST_CBSY] = 1'b1;
              else          status_d = '0;
            end
            2'd1: begin
              command_d   = '0;
              memaddr_d   = '0;
              status_d    = '0;
              startio_d   = 1'b1;
              stbusy_d    = 1'b1;
              timer_clear = 1'b1;
            end
            2'd2: begin
              if (stbusy_q) begin
                status_d[ST_CBSY] = 1'b1;
              end else begin
                command_d[11:9] = FN_SEEK;
                command_d[7:0]  = '0;
                diskaddr_d      = '0;
                startio_d       = 1'b1;
                stbusy_d        = 1'b1;
              end
            end
            default: begin
              status_d    = '0;
              startio_d   = 1'b1;
              timer_clear = 1'b1;
            end
          endcase
        end
        IOP_DLAG: begin
          if (stbusy_q) begin
            status_d[ST_CBSY] = 1'b1;
          end else begin
            ac_clear_d = 1'b1;
            devtocpu_d = '0;
            diskaddr_d = cputodev;
            if (int'(drv) >= NDRIVES) begin
              status_d[ST_FLNR] = 1'b1;
            end else if (command_q[11:9] == FN_SEEK) begin
              // Seeks run locally; the ARM is not involved
              timer_load[drv] = 1'b1;
              cyl_d[drv]      = cputodev[11:4];
            end else if (timer_busy[drv]) begin
              status_d[ST_HDIM] = 1'b1;
              status_d[ST_CBSY] = 1'b1;
            end else begin
              startio_d = 1'b1;
              stbusy_d  = 1'b1;
            end
          end
        end
        IOP_DLCA: begin
          if (stbusy_q) begin
            status_d[ST_CBSY] = 1'b1;
          end else begin
            memaddr_d  = cputodev;
            ac_clear_d = 1'b1;
            devtocpu_d = '0;
          end
        end
        IOP_DRST: begin
          ac_clear_d = 1'b1;
          devtocpu_d = {status_q[ST_DONE], timer_busy[drv], status_q[9:0]};
        end
        IOP_DLDC: begin
          if (stbusy_q) begin
            status_d[ST_CBSY] = 1'b1;
          end else begin
            command_d  = cputodev;
            ac_clear_d = 1'b1;
            devtocpu_d = '0;
            status_d   = '0;
          end
        end
        default: ;
      endcase
    end else if (iopstop) begin
      devtocpu_d = '0;
      ac_clear_d = 1'b0;
      io_skip_d  = 1'b0;
    end

    // Seek completion: an ARM write of the same register wins, IOPs lose
    if (!(armwrite && armwaddr == 4'd7)) seekdone_d = seekdone_d | timer_expire;
    if (!(armwrite && armwaddr == 4'd4) && done_hit) status_d[ST_DONE] = 1'b1;
  end

  // State registers; RESET/BINIT clear all, only RESET clears enable
  always_ff @(posedge CLOCK) begin
    if (rst_any) begin
      command_q   <= '0;
      diskaddr_q  <= '0;
      memaddr_q   <= '0;
      status_q    <= '0;
      startio_q   <= 1'b0;
      stbusy_q    <= 1'b0;
      enable_q    <= RESET ? 1'b0 : enable_q;
      seekdone_q  <= '0;
      cyl_q       <= '0;
      prescaler_q <= '0;
      devtocpu_q  <= '0;
      ac_clear_q  <= 1'b0;
      io_skip_q   <= 1'b0;
    end else begin
      command_q   <= command_d;
      diskaddr_q  <= diskaddr_d;
      memaddr_q   <= memaddr_d;
      status_q    <= status_d;
      startio_q   <= startio_d;
      stbusy_q    <= stbusy_d;
      enable_q    <= enable_d;
      seekdone_q  <= seekdone_d;
      cyl_q       <= cyl_d;
      prescaler_q <= prescaler_d;
      devtocpu_q  <= devtocpu_d;
      ac_clear_q  <= ac_clear_d;
      io_skip_q   <= io_skip_d;
    end
  end

  // ARM register read mux
  always_comb begin
    armrdata = RK_BAD_ADDR;
    case (armraddr)
      4'd0: armrdata = RK_ID_WORD;
      4'd1: armrdata = {20'b0, command_q};
      4'd2: armrdata = {20'b0, diskaddr_q};
      4'd3: armrdata = {20'b0, memaddr_q};
      4'd4: armrdata = {20'b0, status_q};
      4'd5: armrdata = {29'b0, stbusy_q, startio_q, enable_q};
      4'd6: armrdata = {28'b0, timer_busy};
      4'd7: armrdata = {28'b0, seekdone_q};
      4'd8, 4'd9, 4'd10, 4'd11:
        armrdata = {8'b0, timer_count[armraddr[1:0]], 8'b0, cyl_q[armraddr[1:0]]};
      default: ;
    endcase
  end

  assign devtocpu = devtocpu_q;
  assign AC_CLEAR = ac_clear_q;
  assign IO_SKIP  = io_skip_q;
  assign INT_RQST = (command_q[8] & stskip) | (command_q[7] & (|seekdone_q));

endmodule

// File: tb/tb_pdp8l_rk8je_multi.sv
// Directed bench for pdp8l_rk8je_multi with a scoreboard of expected values.
module tb_pdp8l_rk8je_multi;

  localparam logic [11:0] OP_DSKP = 12'o6741;
  localparam logic [11:0] OP_DLAG = 12'o6743;
  localparam logic [11:0] OP_DLCA = 12'o6744;
  localparam logic [11:0] OP_DRST = 12'o6745;
  localparam logic [11:0] OP_DLDC = 12'o6746;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0, BINIT = 1'b0;
  logic        armwrite = 1'b0;
  logic [3:0]  armraddr = '0, armwaddr = '0;
  logic [31:0] armwdata = '0;
  logic [31:0] armrdata;
  logic        iopstart = 1'b0, iopstop = 1'b0;
  logic [11:0] ioopcode = '0, cputodev = '0;
  logic [11:0] devtocpu;
  logic        AC_CLEAR, IO_SKIP, INT_RQST;

  pdp8l_rk8je_multi #(
    .DEVCODE(6'o74), .NDRIVES(2), .TICKDIV(2), .SEEKTICKS(3)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .BINIT(BINIT),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode),
    .cputodev(cputodev), .devtocpu(devtocpu),
    .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP), .INT_RQST(INT_RQST)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic arm_wr(input logic [3:0] a, input logic [31:0] d);
    armwrite = 1'b1; armwaddr = a; armwdata = d;
    step();
    armwrite = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] v);
    expect_val(tag, v);
    armraddr = a;
    #1;
    check(armrdata);
  endtask

  task automatic iop(input logic [11:0] opc, input logic [11:0] ac);
    ioopcode = opc; cputodev = ac; iopstart = 1'b1;
    step();
    iopstart = 1'b0;
  endtask

  task automatic iop_end();
    iopstop = 1'b1;
    step();
    iopstop = 1'b0;
  endtask

  initial begin
    int   busy_n;
    logic done;
    logic [11:0] seek_ac;

    RESET = 1'b1;
    step(); step();
    RESET = 1'b0;

    // Reset state
    expect_val("rst_devtocpu", 32'h0); check({20'b0, devtocpu});
    expect_val("rst_ac_clear", 32'h0); check({31'b0, AC_CLEAR});
    expect_val("rst_io_skip",  32'h0); check({31'b0, IO_SKIP});
    expect_val("rst_int",      32'h0); check({31'b0, INT_RQST});
    chk_reg("rst_reg5", 4'd5, 32'h0);
    chk_reg("id_word",  4'd0, 32'h524B3004);
    chk_reg("bad_addr", 4'd13, 32'hDEADBEEF);

    // Basic transfer start
    arm_wr(4'd5, 32'd1);
    iop(OP_DLDC, 12'o0400);
    iop_end();
    iop(OP_DLAG, 12'o0123);
    expect_val("dlag_ac_clear", 32'h1); check({31'b0, AC_CLEAR});
    expect_val("dlag_devtocpu", 32'h0); check({20'b0, devtocpu});
    chk_reg("dlag_diskaddr", 4'd2, 32'h053);
    chk_reg("dlag_reg5", 4'd5, 32'h7);
    iop_end();
    expect_val("stop_ac_clear", 32'h0); check({31'b0, AC_CLEAR});

    // Seek on drive 1 with completion interrupt enabled
    arm_wr(4'd5, 32'd1);
    iop(OP_DLDC, 12'o3202);
    iop_end();
    seek_ac = 12'o0240;
    iop(OP_DLAG, seek_ac);
    busy_n = 0;
    done   = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      armraddr = 4'd7; #1;
      if (armrdata[1]) done = 1'b1;
      else begin
        armraddr = 4'd6; #1;
        if (armrdata == 32'h2) busy_n++;
        step();
      end
    end
    expect_val("seek_done_seen", 32'h1); check({31'b0, done});
    expect_val("hdim_cycles_5_6", 32'h1); check({31'b0, (busy_n == 5 || busy_n == 6)});
    chk_reg("seek_status_done", 4'd4, 32'h800);
    chk_reg("seek_seekdone", 4'd7, 32'h2);
    expect_val("seek_int", 32'h1); check({31'b0, INT_RQST});
    chk_reg("seek_cyl1", 4'd9, {24'b0, seek_ac[11:4]});
    chk_reg("seek_reg5", 4'd5, 32'h1);
    iop_end();
    iop(OP_DSKP, 12'o0);
    expect_val("seek_dskp", 32'h1); check({31'b0, IO_SKIP});
    iop_end();
    iop(OP_DRST, 12'o0);
    expect_val("drst_devtocpu", 32'h800); check({20'b0, devtocpu});
    expect_val("drst_ac_clear", 32'h1); check({31'b0, AC_CLEAR});
    iop_end();
    arm_wr(4'd7, 32'h2);
    chk_reg("seekdone_clr", 4'd7, 32'h0);
    expect_val("int_after_clr", 32'h0); check({31'b0, INT_RQST});

    // Absent drive 2
    iop(OP_DLDC, 12'o0004);
    iop_end();
    iop(OP_DLAG, 12'o0000);
    chk_reg("flnr_status", 4'd4, 32'h080);
    chk_reg("flnr_reg5", 4'd5, 32'h1);
    iop_end();
    iop(OP_DSKP, 12'o0);
    expect_val("flnr_dskp", 32'h1); check({31'b0, IO_SKIP});
    iop_end();
    expect_val("flnr_stop_skip", 32'h0); check({31'b0, IO_SKIP});

    // DLCA while busy
    arm_wr(4'd3, 32'h1FF);
    arm_wr(4'd4, 32'h0);
    arm_wr(4'd5, 32'd5);
    iop(OP_DLCA, 12'o1000);
    expect_val("dlca_busy_acclr", 32'h0); check({31'b0, AC_CLEAR});
    chk_reg("dlca_busy_memaddr", 4'd3, 32'h1FF);
    chk_reg("dlca_busy_status", 4'd4, 32'h040);
    iop_end();

    // Expiry in the same cycle as an ARM status write
    arm_wr(4'd5, 32'd1);
    iop(OP_DLDC, 12'o3202);
    iop_end();
    iop(OP_DLAG, 12'o0100);
    armwrite = 1'b1; armwaddr = 4'd4; armwdata = 32'h0; armraddr = 4'd7;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (armrdata[1]) done = 1'b1;
      else step();
    end
    armwrite = 1'b0;
    expect_val("race_done_seen", 32'h1); check({31'b0, done});
    chk_reg("race_status", 4'd4, 32'h0);
    chk_reg("race_seekdone", 4'd7, 32'h2);
    iop_end();
    arm_wr(4'd7, 32'hF);

    // BINIT aborts a seek but keeps enable; RESET clears enable
    iop(OP_DLDC, 12'o3000);
    iop_end();
    iop(OP_DLAG, 12'o0100);
    chk_reg("seek0_hdim", 4'd6, 32'h1);
    BINIT = 1'b1;
    step();
    BINIT = 1'b0;
    chk_reg("binit_hdim", 4'd6, 32'h0);
    chk_reg("binit_timer0", 4'd8, 32'h0);
    chk_reg("binit_status", 4'd4, 32'h0);
    chk_reg("binit_reg5", 4'd5, 32'h1);
    expect_val("binit_ac_clear", 32'h0); check({31'b0, AC_CLEAR});
    for (int i = 0; i < 10; i++) step();
    chk_reg("binit_no_done", 4'd7, 32'h0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk_reg("reset_reg5", 4'd5, 32'h0);
    iop(OP_DLDC, 12'o0400);
    chk_reg("disabled_cmd", 4'd1, 32'h0);
    expect_val("disabled_acclr", 32'h0); check({31'b0, AC_CLEAR});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
